// File: rtl/stream_wr_pkg.sv
// Shared types and sizing helpers for the stream-to-burst writer.
package stream_wr_pkg;

  localparam int unsigned LEN_BITS = 10;

  typedef enum logic [0:0] {S_IDLE, S_BURST} state_e;

  function automatic int unsigned calc_ratio(input int unsigned mem_bits,
                                             input int unsigned in_width);
    return mem_bits / in_width;
  endfunction

  function automatic int unsigned calc_lane_bits(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Values for the default 32-bit samples packed into 256-bit words.
  localparam int unsigned RATIO     = calc_ratio(256, 32);
  localparam int unsigned LANE_BITS = calc_lane_bits(RATIO);

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO; a push and a pop together on a full FIFO are allowed.
module sync_fifo_fwft #(
  parameter  int unsigned WIDTH    = 256,
  parameter  int unsigned DEPTH    = 512,
  localparam int unsigned PTR_BITS = $clog2(DEPTH),
  localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_push_data,
  input  logic                i_pop,
  output logic [WIDTH-1:0]    o_head,
  output logic                o_full,
  output logic                o_empty,
  output logic [CNT_BITS-1:0] o_count
);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_BITS'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // An empty pop is ignored so the head simply holds its last value.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stream_wr_burst.sv
// Packs a narrow sample stream into wide words and issues fixed-length ring-buffer write bursts.
// Optional STREAM_WR_STATS_EN adds burst, word and stall counters.
module stream_wr_burst
  import stream_wr_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 32,
  parameter int unsigned MEM_DATA_BITS = 256,
  parameter int unsigned ADDR_BITS     = 28,
  parameter int unsigned BURST_LEN     = 128,
  parameter int unsigned FIFO_DEPTH    = 512,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned REGION_WORDS  = 2 ** 20
) (
  input  logic                     i_mem_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic [IN_WIDTH-1:0]      i_s_data,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  output logic                     o_wr_burst_req,
  output logic [LEN_BITS-1:0]      o_wr_burst_len,
  output logic [ADDR_BITS-1:0]     o_wr_burst_addr,
  input  logic                     i_wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] o_wr_burst_data,
  input  logic                     i_wr_burst_finish,
  output logic                     o_busy,
  output logic                     o_underflow
`ifdef STREAM_WR_STATS_EN
  ,
  output logic [31:0]              o_burst_cnt,
  output logic [31:0]              o_word_cnt,
  output logic [31:0]              o_stall_cnt
`endif
);

  localparam int unsigned NUM_LANES = calc_ratio(MEM_DATA_BITS, IN_WIDTH);
  localparam int unsigned LANE_W    = calc_lane_bits(NUM_LANES);
  localparam int unsigned CNT_BITS  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_BITS:0] RING_END = (ADDR_BITS + 1)'(BASE_ADDR + REGION_WORDS);

  state_e                   r_state;
  state_e                   w_state_next;
  logic [LANE_W-1:0]        r_lane;
  logic [MEM_DATA_BITS-1:0] r_acc;
  logic [MEM_DATA_BITS-1:0] r_push_word;
  logic [MEM_DATA_BITS-1:0] w_merged;
  logic                     r_push_v;
  logic                     r_flush_pend;
  logic                     r_underflow;
  logic [LEN_BITS-1:0]      r_len;
  logic [LEN_BITS-1:0]      w_start_len;
  logic [ADDR_BITS-1:0]     r_addr;
  logic [ADDR_BITS-1:0]     r_burst_addr;
  logic [ADDR_BITS:0]       w_addr_sum;
  logic [CNT_BITS-1:0]      w_count;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_full_eff;
  logic                     w_lane_last;
  logic                     w_accept;
  logic                     w_flush_part;
  logic                     w_pop;
  logic                     w_start;
  logic                     w_finish;
  logic                     w_flush_done;

  sync_fifo_fwft #(
    .WIDTH (MEM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_mem_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_push_v),
    .i_push_data (r_push_word),
    .i_pop       (w_pop),
    .o_head      (o_wr_burst_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  // The packed word lands in the FIFO a cycle after acceptance, so count it as already there.
  assign w_full_eff  = w_fifo_full | (r_push_v & (w_count == CNT_BITS'(FIFO_DEPTH - 1)));
  assign w_lane_last = (r_lane == LANE_W'(NUM_LANES - 1));
  assign o_s_ready   = i_enable & ~r_flush_pend & ~(w_full_eff & w_lane_last);
  assign w_accept    = i_s_valid & o_s_ready;
  assign w_flush_part = r_flush_pend & (r_lane != '0) & ~r_push_v & ~w_full_eff;

  always_comb begin
    w_merged = r_acc;
    w_merged[r_lane * IN_WIDTH +: IN_WIDTH] = i_s_data;
  end

  // Packer: unused lanes of r_acc stay zero, which provides the flush padding.
  always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane      <= '0;
      r_acc       <= '0;
      r_push_word <= '0;
      r_push_v    <= 1'b0;
    end else begin
      r_push_v <= 1'b0;
      if (w_accept) begin
        if (w_lane_last) begin
          r_push_word <= w_merged;
          r_push_v    <= 1'b1;
          r_acc       <= '0;
          r_lane      <= '0;
        end else begin
          r_acc  <= w_merged;
          r_lane <= r_lane + LANE_W'(1);
        end
      end else if (w_flush_part) begin
        r_push_word <= r_acc;
        r_push_v    <= 1'b1;
        r_acc       <= '0;
        r_lane      <= '0;
      end
    end
  end

  assign w_start = (r_state == S_IDLE) &
                   ((i_enable & (w_count >= CNT_BITS'(BURST_LEN))) |
                    (r_flush_pend & (w_count != '0)));
  assign w_start_len  = (w_count < CNT_BITS'(BURST_LEN)) ? LEN_BITS'(w_count)
                                                          : LEN_BITS'(BURST_LEN);
  assign w_finish     = (r_state == S_BURST) & i_wr_burst_finish;
  assign w_pop        = (r_state == S_BURST) & i_wr_burst_data_req & ~w_fifo_empty;
  assign w_addr_sum   = {1'b0, r_addr} + (ADDR_BITS + 1)'(r_len);
  assign w_flush_done = r_flush_pend & (r_lane == '0) & ~r_push_v & w_fifo_empty &
                        (r_state == S_IDLE);

  always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start)           w_state_next = S_BURST;
      S_BURST: if (i_wr_burst_finish) w_state_next = S_IDLE;
      default:                        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_wr_burst_req = (r_state == S_BURST);
    o_busy         = (r_state != S_IDLE) | r_flush_pend;
  end

  always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len        <= '0;
      r_burst_addr <= '0;
      r_addr       <= ADDR_BITS'(BASE_ADDR);
      r_flush_pend <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_start) begin
        r_len        <= w_start_len;
        r_burst_addr <= r_addr;
      end
      if (w_finish) begin
        r_addr <= (w_addr_sum >= RING_END) ? ADDR_BITS'(BASE_ADDR) : w_addr_sum[ADDR_BITS-1:0];
      end
      if (i_flush)           r_flush_pend <= 1'b1;
      else if (w_flush_done) r_flush_pend <= 1'b0;
      if (i_wr_burst_data_req & w_fifo_empty) r_underflow <= 1'b1;
    end
  end

  assign o_wr_burst_len  = r_len;
  assign o_wr_burst_addr = r_burst_addr;
  assign o_underflow     = r_underflow;

`ifdef STREAM_WR_STATS_EN
  logic [31:0] r_burst_cnt;
  logic [31:0] r_word_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_mem_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_burst_cnt <= '0;
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_finish)                r_burst_cnt <= r_burst_cnt + 32'd1;
      if (w_pop)                   r_word_cnt  <= r_word_cnt + 32'd1;
      if (i_s_valid & ~o_s_ready)  r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_burst_cnt = r_burst_cnt;
  assign o_word_cnt  = r_word_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
